pwm_ramp_sequencer: RTL and testbench

PWM_RAMP_SEQUENCER -- requirements
Module: pwm_ramp_sequencer

---
 rtl/pwm_ramp_sequencer.sv | 140 ++++++++++++++
 tb/tb_pwm_ramp_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer
// Walks a PWM duty-cycle register from its current value toward a target in
// fixed-size steps spaced a programmable number of clock cycles apart.
// Steps saturate at the target, so the ramp never overshoots or wraps.
// duty_we strobes the PWM duty register once for every change of duty_out.
module pwm_ramp_sequencer #(
  parameter int INTERVAL_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            target_duty,
  input  logic [7:0]            step,
  input  logic [INTERVAL_W-1:0] interval,
  output logic [7:0]            duty_out,
  output logic                  duty_we,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [INTERVAL_W-1:0] CNT_ONE = {{(INTERVAL_W-1){1'b0}}, 1'b1};

  state_t                r_state;
  logic [7:0]            r_duty;
  logic                  r_duty_we;
  logic                  r_busy;
  logic                  r_done;
  logic [INTERVAL_W-1:0] r_cnt;
  logic [7:0]            r_target;
  logic [7:0]            r_step;
  logic [INTERVAL_W-1:0] r_interval;
  logic                  r_dir_up;

  // A zero step or interval would stall the ramp, so both are promoted to 1.
  logic [7:0]            w_step_eff;
  logic [INTERVAL_W-1:0] w_interval_eff;

  assign w_step_eff     = (step == 8'd0) ? 8'd1 : step;
  assign w_interval_eff = (interval == '0) ? CNT_ONE : interval;

  // Candidate next duty value, computed one bit wider so that overflow above
  // 255 and borrow below 0 are visible and clamp to the target instead.
  logic [8:0] w_up_sum;
  logic [8:0] w_dn_diff;
  logic [7:0] w_up_val;
  logic [7:0] w_dn_val;
  logic [7:0] w_next_duty;

  assign w_up_sum  = {1'b0, r_duty} + {1'b0, r_step};
  assign w_dn_diff = {1'b0, r_duty} - {1'b0, r_step};

  assign w_up_val  = (w_up_sum >= {1'b0, r_target}) ? r_target : w_up_sum[7:0];
  assign w_dn_val  = (w_dn_diff[8] || (w_dn_diff[7:0] <= r_target)) ? r_target
                                                                     : w_dn_diff[7:0];
  assign w_next_duty = r_dir_up ? w_up_val : w_dn_val;

  // Sequencer state machine; every output is a register updated here.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order in this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_duty     <= 8'd0;
      r_duty_we  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cnt      <= '0;
      r_target   <= 8'd0;
      r_step     <= 8'd0;
      r_interval <= '0;
      r_dir_up   <= 1'b0;
    end else begin
      // Strobes default low and are raised only on the edge that earns them.
      r_duty_we <= 1'b0;
      r_done    <= 1'b0;

      unique case (r_state)
        IDLE: begin
          // abort outranks start; inputs are latched so later changes are inert.
          if (start && !abort) begin
            r_target   <= target_duty;
            r_step     <= w_step_eff;
            r_interval <= w_interval_eff;
            r_cnt      <= w_interval_eff - CNT_ONE;
            r_dir_up   <= (target_duty > r_duty);
            r_busy     <= 1'b1;
            if (target_duty == r_duty) begin
              r_state <= FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state <= RAMP;
            end
          end
        end

        RAMP: begin
          if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            // target != duty in RAMP and step >= 1, so every step is a change.
            r_duty    <= w_next_duty;
            r_duty_we <= 1'b1;
            r_cnt     <= r_interval - CNT_ONE;
            if (w_next_duty == r_target) begin
              r_state <= FINISH;
              r_done  <= 1'b1;
            end
          end
        end

        FINISH: begin
          // done was raised on entry; leave after its single cycle (or on abort).
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign duty_out = r_duty;
  assign duty_we  = r_duty_we;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// tb_pwm_ramp_sequencer
// Directed scenarios with hand-computed expected duty/strobe sequences.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_pwm_ramp_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  target_duty;
  logic [7:0]  step;
  logic [15:0] interval;
  logic [7:0]  duty_out;
  logic        duty_we;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_ramp_sequencer #(.INTERVAL_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .target_duty (target_duty),
    .step        (step),
    .interval    (interval),
    .duty_out    (duty_out),
    .duty_we     (duty_we),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start request for exactly one edge (edge 0 of the ramp).
  task automatic launch(input logic [7:0] t, input logic [7:0] s, input logic [15:0] iv);
    target_duty = t;
    step        = s;
    interval    = iv;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    target_duty = 8'd0; step = 8'd0; interval = 16'd0;
    tick();
    tick();
    n_tests++;
    if ({duty_out, duty_we, busy, done} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got duty=%0d we=%0b busy=%0b done=%0b, expected all 0",
               duty_out, duty_we, busy, done);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if ({duty_out, duty_we, busy, done} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_idle_hold: got duty=%0d we=%0b busy=%0b done=%0b, expected all 0",
               duty_out, duty_we, busy, done);
    end
  endtask

  // 0 -> 10, step 3, interval 2: updates 3,6,9,10 at edges +2,+4,+6,+8.
  task automatic test_ramp_up();
    logic [7:0] exp_duty [8] = '{8'd0, 8'd3, 8'd3, 8'd6, 8'd6, 8'd9, 8'd9, 8'd10};
    logic       exp_we   [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       exp_done [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int we_count = 0;
    launch(8'd10, 8'd3, 16'd2);
    n_tests++;
    if (busy !== 1'b1 || duty_out !== 8'd0) begin
      n_fail++;
      $display("FAIL up_start: got busy=%0b duty=%0d, expected busy=1 duty=0", busy, duty_out);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      we_count += int'(duty_we);
      n_tests++;
      if (duty_out !== exp_duty[i] || duty_we !== exp_we[i] ||
          done !== exp_done[i] || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL up_edge%0d: got duty=%0d we=%0b done=%0b busy=%0b, expected duty=%0d we=%0b done=%0b busy=1",
                 i + 1, duty_out, duty_we, done, busy, exp_duty[i], exp_we[i], exp_done[i]);
      end
    end
    tick();
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || duty_we !== 1'b0 || duty_out !== 8'd10) begin
      n_fail++;
      $display("FAIL up_after: got busy=%0b done=%0b we=%0b duty=%0d, expected 0 0 0 10",
               busy, done, duty_we, duty_out);
    end
    n_tests++;
    if (we_count !== 4) begin
      n_fail++;
      $display("FAIL up_we_count: got %0d, expected 4", we_count);
    end
  endtask

  // 10 -> 0, step 4, interval 0 (treated as 1): 6, 2, 0 on consecutive edges.
  task automatic test_ramp_down_zero_interval();
    logic [7:0] exp_duty [3] = '{8'd6, 8'd2, 8'd0};
    logic       exp_done [3] = '{1'b0, 1'b0, 1'b1};
    launch(8'd0, 8'd4, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (duty_out !== exp_duty[i] || duty_we !== 1'b1 || done !== exp_done[i]) begin
        n_fail++;
        $display("FAIL down_edge%0d: got duty=%0d we=%0b done=%0b, expected duty=%0d we=1 done=%0b",
                 i + 1, duty_out, duty_we, done, exp_duty[i], exp_done[i]);
      end
    end
    tick();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || duty_we !== 1'b0 || duty_out !== 8'd0) begin
      n_fail++;
      $display("FAIL down_after: got done=%0b busy=%0b we=%0b duty=%0d, expected 0 0 0 0",
               done, busy, duty_we, duty_out);
    end
  endtask

  task automatic test_saturation();
    // Reach 250 in one step, then 250 + 200 must clamp to 255, not wrap.
    launch(8'd250, 8'd250, 16'd1);
    tick();
    tick();
    n_tests++;
    if (duty_out !== 8'd250 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_setup: got duty=%0d busy=%0b, expected duty=250 busy=0", duty_out, busy);
    end
    launch(8'd255, 8'd200, 16'd1);
    tick();
    n_tests++;
    if (duty_out !== 8'd255 || duty_we !== 1'b1 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_clamp: got duty=%0d we=%0b done=%0b, expected duty=255 we=1 done=1",
               duty_out, duty_we, done);
    end
    tick();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_after: got done=%0b busy=%0b, expected 0 0", done, busy);
    end
    // Zero step behaves as step 1: 0 -> 1 -> 2.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    launch(8'd2, 8'd0, 16'd1);
    tick();
    n_tests++;
    if (duty_out !== 8'd1 || duty_we !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL step0_first: got duty=%0d we=%0b done=%0b, expected duty=1 we=1 done=0",
               duty_out, duty_we, done);
    end
    tick();
    n_tests++;
    if (duty_out !== 8'd2 || duty_we !== 1'b1 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL step0_second: got duty=%0d we=%0b done=%0b, expected duty=2 we=1 done=1",
               duty_out, duty_we, done);
    end
    tick();
  endtask

  task automatic test_abort();
    int done_seen = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    // 0 -> 100, step 10, interval 3: 10, 20, 30 at edges +3, +6, +9.
    launch(8'd100, 8'd10, 16'd3);
    repeat (9) tick();
    n_tests++;
    if (duty_out !== 8'd30 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: got duty=%0d busy=%0b, expected duty=30 busy=1", duty_out, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_tests++;
    if (duty_out !== 8'd30 || busy !== 1'b0 || done !== 1'b0 || duty_we !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_edge: got duty=%0d busy=%0b done=%0b we=%0b, expected 30 0 0 0",
               duty_out, busy, done, duty_we);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      done_seen += int'(done) + int'(duty_we) + int'(busy);
    end
    n_tests++;
    if (done_seen !== 0 || duty_out !== 8'd30) begin
      n_fail++;
      $display("FAIL abort_quiet: got activity=%0d duty=%0d, expected activity=0 duty=30",
               done_seen, duty_out);
    end
    // Restart from the held value: 30 -> 40 after interval edges.
    launch(8'd40, 8'd10, 16'd3);
    tick();
    tick();
    n_tests++;
    if (duty_out !== 8'd30) begin
      n_fail++;
      $display("FAIL restart_wait: got duty=%0d, expected 30", duty_out);
    end
    tick();
    n_tests++;
    if (duty_out !== 8'd40 || done !== 1'b1 || duty_we !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_step: got duty=%0d done=%0b we=%0b, expected duty=40 done=1 we=1",
               duty_out, done, duty_we);
    end
    tick();
    // abort wins over start in IDLE: nothing moves.
    target_duty = 8'd90; step = 8'd50; interval = 16'd1;
    abort = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || duty_out !== 8'd40 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_priority: got busy=%0b duty=%0d done=%0b, expected busy=0 duty=40 done=0",
               busy, duty_out, done);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0 || duty_out !== 8'd40) begin
      n_fail++;
      $display("FAIL abort_priority_hold: got busy=%0b duty=%0d, expected busy=0 duty=40",
               busy, duty_out);
    end
  endtask

  task automatic test_equal_target();
    launch(8'd40, 8'd5, 16'd1);
    n_tests++;
    if (done !== 1'b1 || duty_we !== 1'b0 || busy !== 1'b1 || duty_out !== 8'd40) begin
      n_fail++;
      $display("FAIL equal_done: got done=%0b we=%0b busy=%0b duty=%0d, expected 1 0 1 40",
               done, duty_we, busy, duty_out);
    end
    tick();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || duty_we !== 1'b0) begin
      n_fail++;
      $display("FAIL equal_after: got done=%0b busy=%0b we=%0b, expected 0 0 0", done, busy, duty_we);
    end
  endtask

  // Start and new parameters presented mid-ramp must not disturb it.
  task automatic test_back_to_back();
    logic [7:0] exp_duty [4] = '{8'd43, 8'd43, 8'd46, 8'd46};
    logic       exp_done [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_busy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    launch(8'd46, 8'd3, 16'd2);
    tick();
    target_duty = 8'd0; step = 8'd1; interval = 16'd1;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) start = 1'b0;
      n_tests++;
      if (duty_out !== exp_duty[i] || done !== exp_done[i] || busy !== exp_busy[i]) begin
        n_fail++;
        $display("FAIL busy_ignore_edge%0d: got duty=%0d done=%0b busy=%0b, expected duty=%0d done=%0b busy=%0b",
                 i + 2, duty_out, done, busy, exp_duty[i], exp_done[i], exp_busy[i]);
      end
    end
  endtask

  task automatic test_reset_midramp();
    launch(8'd200, 8'd1, 16'd1);
    tick();
    tick();
    n_tests++;
    if (duty_out !== 8'd48 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: got duty=%0d busy=%0b, expected duty=48 busy=1", duty_out, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({duty_out, duty_we, busy, done} !== 11'd0) begin
      n_fail++;
      $display("FAIL midrst: got duty=%0d we=%0b busy=%0b done=%0b, expected all 0",
               duty_out, duty_we, busy, done);
    end
    tick();
    n_tests++;
    if ({duty_out, duty_we, busy, done} !== 11'd0) begin
      n_fail++;
      $display("FAIL midrst_after: got duty=%0d we=%0b busy=%0b done=%0b, expected all 0",
               duty_out, duty_we, busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down_zero_interval();
    test_saturation();
    test_abort();
    test_equal_target();
    test_back_to_back();
    test_reset_midramp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
